// File: rtl/move_command_generator.sv
// Move-command producer: turns raw left/right/rotate buttons into strobed
// tetris commands with synchronisation, debounce and lateral auto-repeat.
package tetris_pkg;
  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_LEFT   = 2'd1,
    CMD_RIGHT  = 2'd2,
    CMD_ROTATE = 2'd3
  } command_t;
endpackage

module move_command_generator
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DAS_CYCLES      = 64,
  parameter int ARR_CYCLES      = 16,
  parameter int STROBE_CYCLES   = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     btn_left,
  input  logic     btn_right,
  input  logic     btn_rotate,
  output command_t move,
  output logic     move_valid,
  output logic     move_clk,
  output logic     busy
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int RPW     = $clog2(REP_MAX + 1);
  localparam int PW      = $clog2(STROBE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  // Button vectors are indexed {rotate, right, left}.
  logic [2:0]     sync1, sync2, deb, deb_next, flip, rise;
  logic [DBW-1:0] deb_cnt [3];

  logic [RPW-1:0] rep_cnt [2];
  logic [RPW-1:0] rep_cnt_next [2];
  logic [1:0]     rep_fire;
  logic           both_held;

  logic [2:0]     pend, req, issue_clr;

  state_t         state, state_next;
  command_t       cmd, cmd_next;
  logic [PW-1:0]  phase_cnt, phase_next;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flip[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1));
    end
  end

  assign deb_next = deb ^ flip;
  assign rise     = flip & ~deb;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_rotate, btn_right, btn_left};
      sync2 <= sync1;
      deb   <= deb_next;
      for (int i = 0; i < 3; i++) begin
        if ((sync2[i] == deb[i]) || flip[i]) deb_cnt[i] <= '0;
        else                                 deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  // A zero repeat count means "not repeating"; it only restarts on a fresh press.
  always_comb begin
    both_held = deb_next[0] & deb_next[1];
    for (int i = 0; i < 2; i++) begin
      rep_fire[i]     = 1'b0;
      rep_cnt_next[i] = rep_cnt[i];
      if (!deb_next[i] || both_held) begin
        rep_cnt_next[i] = '0;
      end else if (rise[i]) begin
        rep_cnt_next[i] = RPW'(DAS_CYCLES);
      end else if (rep_cnt[i] == RPW'(1)) begin
        rep_fire[i]     = 1'b1;
        rep_cnt_next[i] = RPW'(ARR_CYCLES);
      end else if (rep_cnt[i] != '0) begin
        rep_cnt_next[i] = rep_cnt[i] - 1'b1;
      end
    end
  end

  assign req = {rise[2], rise[1] | rep_fire[1], rise[0] | rep_fire[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < 2; i++) rep_cnt[i] <= rep_cnt_next[i];
      pend <= req | (pend & ~issue_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= CMD_NONE;
      phase_cnt <= '0;
    end else begin
      state     <= state_next;
      cmd       <= cmd_next;
      phase_cnt <= phase_next;
    end
  end

  // Command selection priority is rotate, then left, then right.
  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    phase_next = phase_cnt;
    issue_clr  = 3'b000;
    move       = CMD_NONE;
    move_valid = 1'b0;
    move_clk   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pend[2]) begin
          cmd_next   = CMD_ROTATE;
          issue_clr  = 3'b100;
          state_next = SETUP;
        end else if (pend[0]) begin
          cmd_next   = CMD_LEFT;
          issue_clr  = 3'b001;
          state_next = SETUP;
        end else if (pend[1]) begin
          cmd_next   = CMD_RIGHT;
          issue_clr  = 3'b010;
          state_next = SETUP;
        end
      end
      SETUP: begin
        move       = cmd;
        move_valid = 1'b1;
        phase_next = PW'(STROBE_CYCLES - 1);
        state_next = STROBE;
      end
      STROBE: begin
        move       = cmd;
        move_valid = 1'b1;
        move_clk   = 1'b1;
        if (phase_cnt == '0) begin
          phase_next = PW'(STROBE_CYCLES - 1);
          state_next = RECOVER;
        end else begin
          phase_next = phase_cnt - 1'b1;
        end
      end
      RECOVER: begin
        move       = cmd;
        move_valid = 1'b1;
        if (phase_cnt == '0) state_next = IDLE;
        else                 phase_next = phase_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_command_generator.sv
// Bench for move_command_generator: directed segment table, hand-written
// corner sequences and random button activity against a cycle-level model.
module tb_move_command_generator;
  import tetris_pkg::*;

  localparam int DEB = 4;
  localparam int DAS = 10;
  localparam int ARR = 3;
  localparam int STB = 2;
  localparam int NSEG = 18;

  logic     clk = 1'b0;
  logic     reset = 1'b1;
  logic     btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0;
  command_t move;
  logic     move_valid, move_clk, busy;

  move_command_generator #(
    .DEBOUNCE_CYCLES(DEB), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .STROBE_CYCLES(STB)
  ) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .move(move), .move_valid(move_valid),
    .move_clk(move_clk), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_count = 0;
  int rise_cnt [4];
  int rise_cyc [$];
  command_t rise_cmd [$];
  logic prev_clk = 1'b0;

  // Reference model; button index 0=left, 1=right, 2=rotate.
  bit       m_s1 [3], m_s2 [3], m_deb [3], m_pend [3];
  bit       m_hist [3][DEB];
  bit       m_active [2];
  int       m_due [2];
  int       m_phase = 0;
  int       m_cyc = 0;
  command_t m_cmd = CMD_NONE;
  command_t m_move = CMD_NONE;
  bit       m_valid = 0, m_clk = 0, m_busy = 0;

  always @(posedge clk) begin : model
    bit raw [3];
    bit deb_n [3], rise [3], req [3];
    bit all_diff, both;
    int sel;
    raw[0] = btn_left; raw[1] = btn_right; raw[2] = btn_rotate;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_pend[b] = 0;
        for (int k = 0; k < DEB; k++) m_hist[b][k] = 0;
      end
      m_active[0] = 0; m_active[1] = 0;
      m_phase = 0;
      m_cmd = CMD_NONE;
    end else begin
      // Debounced level flips once the last DEB synchronised samples all disagree with it.
      for (int b = 0; b < 3; b++) begin
        for (int k = DEB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s2[b];
        all_diff = 1;
        for (int k = 0; k < DEB; k++) if (m_hist[b][k] == m_deb[b]) all_diff = 0;
        deb_n[b] = all_diff ? !m_deb[b] : m_deb[b];
        rise[b] = all_diff && !m_deb[b];
        req[b] = rise[b];
      end
      both = deb_n[0] && deb_n[1];
      for (int b = 0; b < 2; b++) begin
        if (rise[b]) begin
          m_active[b] = !both;
          m_due[b] = m_cyc + 1 + DAS;
        end else if (!deb_n[b] || both) begin
          m_active[b] = 0;
        end else if (m_active[b] && (m_cyc + 1 == m_due[b])) begin
          req[b] = 1;
          m_due[b] = m_due[b] + ARR;
        end
      end
      sel = -1;
      if (m_phase == 0) begin
        if (m_pend[2]) sel = 2;
        else if (m_pend[0]) sel = 0;
        else if (m_pend[1]) sel = 1;
        if (sel >= 0) begin
          m_phase = 1;
          m_cmd = (sel == 2) ? CMD_ROTATE : (sel == 0) ? CMD_LEFT : CMD_RIGHT;
        end
      end else if (m_phase == 2 * STB + 1) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
      for (int b = 0; b < 3; b++) begin
        m_pend[b] = req[b] || (m_pend[b] && (sel != b));
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
        m_deb[b] = deb_n[b];
      end
    end
    m_cyc = m_cyc + 1;
    m_busy  = (m_phase != 0);
    m_valid = (m_phase != 0);
    m_move  = (m_phase != 0) ? m_cmd : CMD_NONE;
    m_clk   = (m_phase >= 2) && (m_phase <= STB + 1);
  end

  task automatic checkOutput();
    @(posedge clk);
    @(negedge clk);
    cyc_count++;
    total++;
    if (move !== m_move || move_valid !== m_valid || move_clk !== m_clk || busy !== m_busy) begin
      bad++;
      $display("[TB] FAIL cycle %0d outputs: got move=%0d valid=%b clk=%b busy=%b, want move=%0d valid=%b clk=%b busy=%b",
               cyc_count, move, move_valid, move_clk, busy, m_move, m_valid, m_clk, m_busy);
    end
    if (move_clk === 1'b1 && prev_clk === 1'b0) begin
      rise_cnt[int'(move)]++;
      rise_cyc.push_back(cyc_count);
      rise_cmd.push_back(move);
    end
    prev_clk = move_clk;
  endtask

  task automatic applyStimulus(input logic rst, input logic l, input logic r,
                               input logic rot, input int n);
    reset = rst; btn_left = l; btn_right = r; btn_rotate = rot;
    for (int i = 0; i < n; i++) checkOutput();
  endtask

  typedef struct packed {
    logic rst, l, r, rot;
    int   cycles;
    int   exp_rot, exp_left, exp_right;
  } seg_t;

  seg_t segs [NSEG];

  initial begin
    int k;
    bit seen;

    segs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,   3, 0, 0, 0};
    segs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0,  50, 0, 0, 0};
    segs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1,   2, 0, 0, 0};
    segs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,   6, 0, 0, 0};
    segs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1,   2, 0, 0, 0};
    segs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0,   6, 0, 0, 0};
    segs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 100, 1, 0, 0};
    segs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 0};
    segs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,  46, 0, 6, 0};
    segs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,  30, 0, 2, 0};
    segs[10] = '{1'b0, 1'b0, 1'b1, 1'b1,  12, 1, 0, 0};
    segs[11] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 2};
    segs[12] = '{1'b0, 1'b1, 1'b0, 1'b0,  20, 0, 2, 0};
    segs[13] = '{1'b0, 1'b1, 1'b1, 1'b0,  30, 0, 2, 1};
    segs[14] = '{1'b0, 1'b0, 1'b1, 1'b0,  30, 0, 0, 0};
    segs[15] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 0};
    segs[16] = '{1'b0, 1'b0, 1'b1, 1'b0,  10, 0, 0, 1};
    segs[17] = '{1'b0, 1'b0, 1'b0, 1'b0,  20, 0, 0, 0};

    k = 0;
    for (int s = 0; s < NSEG; s++) begin
      for (int c = 0; c < 4; c++) rise_cnt[c] = 0;
      if (s == 10) k = rise_cmd.size();
      applyStimulus(segs[s].rst, segs[s].l, segs[s].r, segs[s].rot, segs[s].cycles);
      total++;
      if (rise_cnt[3] != segs[s].exp_rot || rise_cnt[1] != segs[s].exp_left ||
          rise_cnt[2] != segs[s].exp_right) begin
        bad++;
        $display("[TB] FAIL seg%0d strobes rot/left/right: got %0d/%0d/%0d want %0d/%0d/%0d", s,
                 rise_cnt[3], rise_cnt[1], rise_cnt[2],
                 segs[s].exp_rot, segs[s].exp_left, segs[s].exp_right);
      end
    end

    // Simultaneous rotate+right: rotate wins, right follows one command period later.
    total++;
    if (rise_cmd.size() < k + 2) begin
      bad++;
      $display("[TB] FAIL rot_right_order: got %0d strobes want at least 2", rise_cmd.size() - k);
    end else begin
      if (rise_cmd[k] != CMD_ROTATE || rise_cmd[k+1] != CMD_RIGHT) begin
        bad++;
        $display("[TB] FAIL rot_right_order: got %0d,%0d want %0d,%0d",
                 rise_cmd[k], rise_cmd[k+1], CMD_ROTATE, CMD_RIGHT);
      end
      total++;
      if (rise_cyc[k+1] - rise_cyc[k] != 2 + 2 * STB) begin
        bad++;
        $display("[TB] FAIL rot_right_spacing: got %0d want %0d",
                 rise_cyc[k+1] - rise_cyc[k], 2 + 2 * STB);
      end
    end

    // Reset during STROBE with a right request still pending.
    reset = 1'b0; btn_left = 1'b0; btn_right = 1'b1; btn_rotate = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      checkOutput();
      if (move_clk === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL strobe_wait: got no move_clk within 20 cycles want a strobe");
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    total++;
    if (move !== CMD_NONE || move_valid !== 1'b0 || move_clk !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_strobe: got move=%0d valid=%b clk=%b busy=%b want 0/0/0/0",
               move, move_valid, move_clk, busy);
    end
    for (int c = 0; c < 4; c++) rise_cnt[c] = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 30);
    total++;
    if (rise_cnt[1] + rise_cnt[2] + rise_cnt[3] != 0) begin
      bad++;
      $display("[TB] FAIL after_reset_strobes: got %0d want 0", rise_cnt[1] + rise_cnt[2] + rise_cnt[3]);
    end

    // Random button activity, including short glitches and occasional resets.
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 19) == 0)
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(1, 3));
      else
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(1, 40));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
